fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/imem_be.sv | 37 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] PC_STEP     = 32'd4;
endpackage
`default_nettype wire

// File: rtl/imem_be.sv
`default_nettype none
// ============================================================================
// Module   : imem_be
// Brief    : Byte memory, synchronous byte write, combinational big-endian word read.
// Revision : 1.0
// ============================================================================
module imem_be
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Byte addresses wrap around the end of the array; range errors are flagged upstream.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            o_rdata[8*(INSTR_BYTES-1-k) +: 8] = r_mem[i_raddr + ADDR_W'(k)];
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : IF stage with PC/nPC delayed-branch pair, IF/ID register and fetch errors.
//            Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              le_pc,
    input  logic              le_npc,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              flush,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    output logic [31:0]       pc,
    output logic [31:0]       npc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid,
    output logic              fetch_err,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalled
);
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_fetch_err;

    logic [31:0] w_mem_word;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_bad_fetch;
    logic [31:0] w_fetch_word;

    imem_be #(
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .i_we    (imem_we),
        .i_waddr (imem_waddr),
        .i_wdata (imem_wdata),
        .i_raddr (r_pc[ADDR_W-1:0]),
        .o_rdata (w_mem_word)
    );

    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_out_of_range = ((r_pc >> ADDR_W) != 32'h0);
    assign w_bad_fetch    = w_misaligned || w_out_of_range;
    assign w_fetch_word   = w_bad_fetch ? NOP_INSTR : w_mem_word;

    // The instruction at the old nPC is the delay slot, so a taken branch only retargets nPC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + PC_STEP;
        end else begin
            if (le_pc) begin
                r_pc <= r_npc;
            end
            if (le_npc) begin
                r_npc <= branch_taken ? branch_target : r_npc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= 32'h0;
            r_if_id_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            if (flush) begin
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end else if (le_pc) begin
                r_if_id_instr <= w_fetch_word;
                r_if_id_pc    <= r_pc;
                r_if_id_valid <= !w_bad_fetch;
            end
            if (le_pc && w_bad_fetch) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= 32'h0;
            r_perf_stalled <= 32'h0;
        end else begin
            if (!flush && le_pc && !w_bad_fetch) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!le_pc) begin
                r_perf_stalled <= r_perf_stalled + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalled = r_perf_stalled;
`else
    assign perf_fetched = 32'h0;
    assign perf_stalled = 32'h0;
`endif

    assign pc          = r_pc;
    assign npc         = r_npc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign fetch_err   = r_fetch_err;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit (ADDR_W=9, RESET_PC=0).
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    localparam int AW = 9;

    logic          clk;
    logic          reset;
    logic          le_pc;
    logic          le_npc;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          flush;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [7:0]    imem_wdata;
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic          fetch_err;
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stalled;

    int n_checks;
    int n_errors;

    fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .le_pc         (le_pc),
        .le_npc        (le_npc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .flush         (flush),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .pc            (pc),
        .npc           (npc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fetch_err     (fetch_err),
        .perf_fetched  (perf_fetched),
        .perf_stalled  (perf_stalled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            imem_we    = 1'b1;
            imem_waddr = addr + AW'(k);
            imem_wdata = word[8*(3-k) +: 8];
            tick();
        end
        imem_we = 1'b0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_valid);
        check({tag, "_instr"}, if_id_instr, e_instr);
        check({tag, "_pc"},    if_id_pc,    e_pc);
        check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    endtask

    logic [31:0] exp_stalled;
    logic [31:0] exp_fetched;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        le_pc         = 1'b0;
        le_npc        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        flush         = 1'b0;
        imem_we       = 1'b0;
        imem_waddr    = '0;
        imem_wdata    = 8'h0;

        write_word(9'h000, 32'h2401_0005);
        write_word(9'h004, 32'h0000_0000);
        write_word(9'h008, 32'h8C22_0004);
        write_word(9'h00C, 32'h1111_1111);
        write_word(9'h040, 32'h0022_1820);
        write_word(9'h044, 32'hAC23_0008);
        write_word(9'h048, 32'h3C01_0001);

        check("rst_pc",  pc,  32'h0);
        check("rst_npc", npc, 32'h4);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst_err",     {31'h0, fetch_err}, 32'h0);
        check("rst_fetched", perf_fetched, 32'h0);
        check("rst_stalled", perf_stalled, 32'h0);

        reset  = 1'b0;
        le_pc  = 1'b1;
        le_npc = 1'b1;
        tick();
        check_ifid("f0", 32'h2401_0005, 32'h0, 1'b1);
        check("f0_pc",  pc,  32'h4);
        check("f0_npc", npc, 32'h8);

        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check_ifid("br0", 32'h0, 32'h4, 1'b1);
        check("br0_npc", npc, 32'h40);
        tick();
        check_ifid("delay", 32'h8C22_0004, 32'h8, 1'b1);
        tick();
        check_ifid("target", 32'h0022_1820, 32'h40, 1'b1);
        check("target_pc",  pc,  32'h44);
        check("target_npc", npc, 32'h48);

        le_pc  = 1'b0;
        le_npc = 1'b0;
        tick();
        tick();
        tick();
        check("stall_pc",  pc,  32'h44);
        check("stall_npc", npc, 32'h48);
        check_ifid("stall", 32'h0022_1820, 32'h40, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        exp_stalled = 32'd3;
        exp_fetched = 32'd4;
`else
        exp_stalled = 32'd0;
        exp_fetched = 32'd0;
`endif
        check("perf_stalled", perf_stalled, exp_stalled);
        check("perf_fetched", perf_fetched, exp_fetched);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_ifid("flush", 32'h0, 32'h40, 1'b0);
        check("flush_err", {31'h0, fetch_err}, 32'h0);

        le_pc         = 1'b1;
        le_npc        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        tick();
        check_ifid("pre_bad", 32'hAC23_0008, 32'h44, 1'b1);
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        check_ifid("pre_bad2", 32'h3C01_0001, 32'h48, 1'b1);
        check("pre_bad_err", {31'h0, fetch_err}, 32'h0);
        tick();
        check_ifid("misal", 32'h0, 32'h42, 1'b0);
        check("misal_err", {31'h0, fetch_err}, 32'h1);
        tick();
        check_ifid("oor", 32'h0, 32'h200, 1'b0);
        check("oor_err", {31'h0, fetch_err}, 32'h1);
        le_pc  = 1'b0;
        le_npc = 1'b0;
        tick();
        tick();
        check("err_sticky", {31'h0, fetch_err}, 32'h1);

        #2;
        reset = 1'b1;
        #1;
        check("arst_pc",  pc,  32'h0);
        check("arst_npc", npc, 32'h4);
        check("arst_err", {31'h0, fetch_err}, 32'h0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        tick();
        reset  = 1'b0;
        le_pc  = 1'b1;
        le_npc = 1'b1;
        tick();
        check_ifid("ret0", 32'h2401_0005, 32'h0, 1'b1);
        tick();
        check_ifid("ret1", 32'h0, 32'h4, 1'b1);
        tick();
        check_ifid("ret2", 32'h8C22_0004, 32'h8, 1'b1);
        check("ret_err", {31'h0, fetch_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
